// File: rtl/alu_operand_pipe.sv
// alu_operand_pipe: elastic operand pipeline between the operand source and
// the ALU core. A chain of DEPTH skid-buffer slices carries {A, B, cin} with a
// valid/ready handshake, full throughput, no combinational ready path, a
// synchronous flush and a registered occupancy count.
module alu_operand_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(2*DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_cin,
  output logic [CNT_W-1:0]  count
);

  localparam int PW = 2*DATA_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } slice_state_e;

  // Inter-slice links: slice k presents slice_valid[k]/slice_data[k]
  // downstream and slice_ready[k] upstream.
  logic [DEPTH-1:0] slice_valid;
  logic [DEPTH-1:0] slice_ready;
  logic [PW-1:0]    slice_data [DEPTH];

  logic [PW-1:0] in_payload;
  logic          in_fire;
  logic          out_fire;
  logic          clear;
  logic [CNT_W-1:0] count_q;

  assign in_payload = {in_a, in_b, in_cin};
  assign clear      = reset | flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    slice_state_e  state_q;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic          up_valid;
    logic [PW-1:0] up_data;
    logic          down_ready;
    logic          accept;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_payload;
    end else begin : g_link
      assign up_valid = slice_valid[k-1];
      assign up_data  = slice_data[k-1];
    end

    if (k == DEPTH-1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_mid
      assign down_ready = slice_ready[k+1];
    end

    // Ready and valid come straight from the state register, so no
    // combinational path exists from out_ready back to in_ready.
    assign slice_ready[k] = (state_q != FULL);
    assign slice_valid[k] = (state_q != EMPTY);
    assign slice_data[k]  = main_q;
    assign accept         = up_valid & (state_q != FULL);

    // Slice state machine: main register feeds downstream, skid catches the
    // one extra entry that arrives while downstream stalls.
    always_ff @(posedge clk) begin
      if (clear) begin
        // NOTE: payload registers are cleared too, so out_* read 0 (not X)
        // until a real entry reaches the output.
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        // NOTE: state registers use non-blocking assignment so every slice
        // samples its neighbours' pre-edge values.
        case (state_q)
          EMPTY: begin
            if (accept) begin
              state_q <= HALF;
              main_q  <= up_data;
            end
          end
          HALF: begin
            if (accept && !down_ready) begin
              state_q <= FULL;
              skid_q  <= up_data;
            end else if (accept) begin
              main_q <= up_data;
            end else if (down_ready) begin
              state_q <= EMPTY;
            end
          end
          FULL: begin
            if (down_ready) begin
              state_q <= HALF;
              main_q  <= skid_q;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  assign in_ready  = slice_ready[0];
  assign out_valid = slice_valid[DEPTH-1];
  assign {out_a, out_b, out_cin} = slice_data[DEPTH-1];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Occupancy counter: tracks entries held across all slices; a flush drops
  // both handshakes of its cycle, so it simply returns to zero.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (in_fire && !out_fire) begin
      count_q <= count_q + CNT_W'(1);
    end else if (out_fire && !in_fire) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_alu_operand_pipe.sv
// Self-checking bench for alu_operand_pipe. Three instances (DEPTH 1, 2, 3)
// share clock, reset, flush and input stimulus; each test watches one of them.
// Index d of the *_w arrays corresponds to DEPTH = d+1.
module tb_alu_operand_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        out_ready;

  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [2:0]  out_cin_w;
  logic [31:0] out_a_w [3];
  logic [31:0] out_b_w [3];
  logic [1:0]  cnt1;
  logic [2:0]  cnt2;
  logic [2:0]  cnt3;
  int          count_w [3];

  assign count_w[0] = int'(cnt1);
  assign count_w[1] = int'(cnt2);
  assign count_w[2] = int'(cnt3);

  alu_operand_pipe #(.DATA_W(32), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_a(out_a_w[0]), .out_b(out_b_w[0]), .out_cin(out_cin_w[0]),
    .count(cnt1)
  );

  alu_operand_pipe #(.DATA_W(32), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_a(out_a_w[1]), .out_b(out_b_w[1]), .out_cin(out_cin_w[1]),
    .count(cnt2)
  );

  alu_operand_pipe #(.DATA_W(32), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .out_a(out_a_w[2]), .out_b(out_b_w[2]), .out_cin(out_cin_w[2]),
    .count(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the pipe is a FIFO of {A, B, cin} whose length is count.
  typedef logic [64:0] payload_t;
  payload_t sb[$];
  int n_accepted;
  int n_consumed;

  task automatic apply_reset();
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    sb.delete();
    n_accepted = 0;
    n_consumed = 0;
  endtask

  // One model-checked cycle on instance d with the inputs already driven.
  task automatic cycle(input int d);
    logic acc;
    logic cons;
    check("count_vs_model", 65'(count_w[d]), 65'(sb.size()));
    if (out_valid_w[d]) begin
      if (sb.size() == 0) check("valid_while_model_empty", 65'(out_valid_w[d]), 65'(0));
      else check("out_payload_head", {out_a_w[d], out_b_w[d], out_cin_w[d]}, sb[0]);
    end
    acc  = in_valid && in_ready_w[d];
    cons = out_valid_w[d] && out_ready;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (cons && sb.size() > 0) begin
        void'(sb.pop_front());
        n_consumed++;
      end
      if (acc) begin
        sb.push_back({in_a, in_b, in_cin});
        n_accepted++;
      end
    end
    step();
  endtask

  typedef struct {
    logic        in_valid;
    logic [31:0] a;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_a;
    int          exp_count;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int idx;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    n_accepted = 0; n_consumed = 0;

    // ---- Reset/idle: inputs active during reset must not leak through ----
    in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_valid", 65'(out_valid_w[1]), 65'(0));
      check("rst_out_a", 65'(out_a_w[1]), 65'(0));
      check("rst_count", 65'(count_w[1]), 65'(0));
    end
    reset = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", 65'(in_ready_w[1]), 65'(1));
    sb.delete();

    // ---- Latency/order on DEPTH=2, streaming A=1..8 with out_ready=1 ----
    for (int c = 0; c < 11; c++) begin
      vecs[c].in_valid  = (c < 8);
      vecs[c].a         = 32'(c + 1);
      vecs[c].exp_valid = (c >= 2 && c <= 9);
      vecs[c].chk_data  = (c <= 9);
      vecs[c].exp_a     = (c >= 2) ? 32'(c - 1) : 32'd0;
      vecs[c].exp_count = (c == 0) ? 0 : (c == 1) ? 1 : (c <= 8) ? 2 : (c == 9) ? 1 : 0;
    end
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      in_valid = vecs[c].in_valid;
      in_a     = vecs[c].a;
      in_b     = vecs[c].a << 4;
      in_cin   = vecs[c].a[0];
      check("lat_in_ready", 65'(in_ready_w[1]), 65'(1));
      check("lat_out_valid", 65'(out_valid_w[1]), 65'(vecs[c].exp_valid));
      check("lat_count", 65'(count_w[1]), 65'(vecs[c].exp_count));
      if (vecs[c].chk_data) begin
        check("lat_out_a", 65'(out_a_w[1]), 65'(vecs[c].exp_a));
        check("lat_out_b", 65'(out_b_w[1]), 65'(vecs[c].exp_a << 4));
        check("lat_out_cin", 65'(out_cin_w[1]), 65'(vecs[c].exp_a[0]));
      end
      step();
    end
    in_valid = 1'b0;

    // ---- Fill/backpressure on DEPTH=2: offer A=10..15 with out_ready=0 ----
    apply_reset();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      logic acc;
      in_valid = 1'b1;
      in_a     = 32'(10 + idx);
      in_b     = ~in_a;
      in_cin   = in_a[0];
      acc      = in_ready_w[1];
      cycle(1);
      if (acc) idx++;
    end
    check("fill_accepted", 65'(idx), 65'(4));
    check("fill_in_ready", 65'(in_ready_w[1]), 65'(0));
    check("fill_count", 65'(count_w[1]), 65'(4));
    check("fill_out_a", 65'(out_a_w[1]), 65'(10));
    out_ready = 1'b1;
    for (int c = 0; c < 40 && !(idx == 6 && sb.size() == 0); c++) begin
      logic acc;
      in_valid = (idx < 6);
      in_a     = 32'(10 + idx);
      in_b     = ~in_a;
      in_cin   = in_a[0];
      acc      = in_valid && in_ready_w[1];
      cycle(1);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("fill_drained", 65'(n_consumed), 65'(6));

    // ---- Flush mid-stream on DEPTH=2 ----
    apply_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_a = 32'(32'h20 + c); in_b = 32'(c); in_cin = 1'b0;
      cycle(1);
    end
    check("flush_pre_count", 65'(count_w[1]), 65'(3));
    flush = 1'b1; in_valid = 1'b1; in_a = 32'h55; in_b = 32'h5; in_cin = 1'b1;
    cycle(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 65'(out_valid_w[1]), 65'(0));
    check("flush_count", 65'(count_w[1]), 65'(0));
    check("flush_out_a", 65'(out_a_w[1]), 65'(0));
    check("flush_in_ready", 65'(in_ready_w[1]), 65'(1));
    in_valid = 1'b1; in_a = 32'h77; in_b = 32'h7; in_cin = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("flush_new_not_early", 65'(out_valid_w[1]), 65'(0));
    step();
    check("flush_new_valid", 65'(out_valid_w[1]), 65'(1));
    check("flush_new_a", 65'(out_a_w[1]), 65'(32'h77));

    // ---- Random stall on DEPTH=3: 1000 entries, 50% valid/ready ----
    apply_reset();
    for (int c = 0; c < 20000 && n_consumed < 1000; c++) begin
      in_valid  = (n_accepted < 1000) && ($urandom_range(1) == 1);
      in_a      = $urandom;
      in_b      = $urandom;
      in_cin    = 1'($urandom_range(1));
      out_ready = ($urandom_range(1) == 1);
      if (count_w[2] > 6) check("rand_count_max", 65'(count_w[2]), 65'(6));
      cycle(2);
    end
    in_valid = 1'b0;
    check("rand_all_consumed", 65'(n_consumed), 65'(1000));
    check("rand_final_count", 65'(count_w[2]), 65'(sb.size()));

    // ---- Reset priority over flush while FULL, then DEPTH=1 single entry ----
    apply_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_a = 32'(32'h40 + c); in_b = 32'(c); in_cin = 1'b1;
      cycle(1);
    end
    check("prio_full", 65'(in_ready_w[1]), 65'(0));
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("prio_out_valid", 65'(out_valid_w[1]), 65'(0));
    check("prio_out_a", 65'(out_a_w[1]), 65'(0));
    check("prio_out_cin", 65'(out_cin_w[1]), 65'(0));
    check("prio_count", 65'(count_w[1]), 65'(0));
    check("prio_in_ready", 65'(in_ready_w[1]), 65'(1));
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0; in_cin = 1'b1; out_ready = 1'b1;
    check("d1_in_ready", 65'(in_ready_w[0]), 65'(1));
    step();
    in_valid = 1'b0;
    check("d1_out_valid", 65'(out_valid_w[0]), 65'(1));
    check("d1_out_a", 65'(out_a_w[0]), 65'(32'hFFFF_FFFF));
    check("d1_out_b", 65'(out_b_w[0]), 65'(0));
    check("d1_out_cin", 65'(out_cin_w[0]), 65'(1));
    step();
    check("d1_drained", 65'(out_valid_w[0]), 65'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_pipe.md
Name: alu_operand_pipe

Overview:
- Parametrised elastic pipeline that carries ALU operands (A, B, carry-in) from the operand source to the ALU core.
- Replaces fixed single-cycle capture registers with a chain of DEPTH skid-buffer slices that use a valid/ready handshake.
- Sustains one transfer per cycle under no backpressure and never drops data under backpressure.
- Adds a synchronous flush and an occupancy count.

Parameters:
- DATA_W, 32, width of each operand A and B.
- DEPTH, 2, number of register slices (legal range 1..8). Latency is DEPTH cycles; capacity is 2*DEPTH entries.
- CNT_W, $clog2(2*DEPTH+1), width of the occupancy counter (derived; do not override).

Ports:
- clk  input  1  clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous, active-high; discards all entries
- in_valid  input  1  upstream has an operand set
- in_ready  output  1  pipe can accept this cycle
- in_a  input  DATA_W  operand A
- in_b  input  DATA_W  operand B
- in_cin  input  1  carry-in
- out_valid  output  1  out_a/out_b/out_cin hold a valid entry
- out_ready  input  1  ALU core consumes the entry this cycle
- out_a  output  DATA_W  operand A to the ALU
- out_b  output  DATA_W  operand B to the ALU
- out_cin  output  1  carry-in to the ALU
- count  output  CNT_W  number of valid entries held across all slices

Behaviour:
- Payload: {A, B, cin}, 2*DATA_W+1 bits. All three fields travel together unmodified; cin is captured from in_cin on every accept, never held from a previous entry.
- Transfer rules: accept when in_valid & in_ready; consume when out_valid & out_ready.
- Slice k connects to slice k+1 through the same valid/ready rule; slice 0 faces the input ports and slice DEPTH-1 faces the output ports.
- Each slice has a main register, a skid register and a 2-bit state: EMPTY, HALF (main valid), FULL (main and skid valid).
- Slice up_ready = (state != FULL). It is a registered signal with no combinational path from out_ready to in_ready.
- Slice down_valid = (state != EMPTY); the slice's downstream data is always its main register.
- Slice transitions:
  - EMPTY, accept -> HALF; main <= in.
  - HALF, accept & !down_ready -> FULL; skid <= in.
  - HALF, accept & down_ready -> HALF; main <= in.
  - HALF, !accept & down_ready -> EMPTY.
  - HALF, !accept & !down_ready -> HALF; hold.
  - FULL, down_ready -> HALF; main <= skid. No accept is possible in FULL.
  - FULL, !down_ready -> FULL; hold.
- Latency: an entry accepted in cycle t into an empty pipe appears on out_* with out_valid=1 in cycle t+DEPTH.
- Throughput: 1 entry per cycle while out_ready=1 continuously.
- Backpressure: with out_ready=0 the pipe accepts exactly 2*DEPTH entries, then in_ready=0.
  - out_* holds stable while out_valid=1 and out_ready=0.
  - Entries emerge in strict FIFO order; none are lost or duplicated.
- count:
  - Registered; reflects state after the clock edge.
  - Increments by 1 on an accept-only cycle and decrements by 1 on a consume-only cycle.
  - Unchanged when accept and consume occur in the same cycle.
  - Range 0..2*DEPTH.
- Reset (reset=1), from any state including mid-transfer:
  - All slices go to EMPTY; all main/skid registers go to 0.
  - Outputs: out_valid=0, out_a=0, out_b=0, out_cin=0, count=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Flush:
  - Same effect as reset on the next edge.
  - An input handshake in the flush cycle is dropped, and so is an output handshake (the downstream sees the last entry but the pipe does not count it).
  - reset has priority over flush; both asserted is the same as reset.
- No X propagation: out_* stay 0 until the first accepted entry reaches the output.

Test Plan:
- Reset/idle: assert reset 2 cycles with in_valid=1, in_a=32'hDEAD_BEEF -> out_valid=0, out_a=0, count=0 during reset; in_ready=1 on the first cycle after reset.
- Latency/order: DEPTH=2, out_ready=1, stream A=1..8, B=A<<4, cin=A[0] on consecutive cycles -> first out_valid two cycles after the first accept; out_a=1..8 with no bubbles; out_cin alternates 1,0,1,...; count steady at 2.
- Fill/backpressure: DEPTH=2, out_ready=0, offer 6 entries A=10..15 -> exactly 4 accepted (10..13), then in_ready=0 and count=4; out_a stays 10. Raise out_ready -> outputs 10,11,12,13, then 14,15 in order.
- Random stall: DEPTH=3, random in_valid/out_ready at 50%, 1000 entries -> scoreboard matches exactly (A, B, cin); count equals the scoreboard depth every cycle; count never exceeds 6.
- Flush mid-stream: DEPTH=2, 3 entries held, assert flush with in_valid=1, A=32'h55 -> next cycle out_valid=0, count=0, out_a=0. Entry 32'h55 never appears; a subsequent entry A=32'h77 arrives after DEPTH cycles.
- Reset priority: reset=1 and flush=1 together while FULL -> same result as reset alone; then DEPTH=1 delivers a single entry A=32'hFFFF_FFFF, B=0, cin=1 in 1 cycle with out_cin=1.
